// File: rtl/fir_mac_sequencer.sv
// -----------------------------------------------------------------------------
// fir_mac_sequencer
//
// Time-multiplexed 4-tap FIR controller. A single signed 16x16 multiplier and
// one accumulator are shared across the four taps, so one output sample takes
// four MAC cycles plus one output cycle. The block owns the 4-entry sample
// delay line and the 4 coefficient registers, and sits between a sample
// source and a sink on valid/ready handshakes.
//
// Parameters:
//   COEFS      reset coefficients, c[k] = COEFS[63-16k -: 16], signed Q1.15
//   FRAC_BITS  right shift applied to the rounded accumulator (1..30)
//   ACC_W      accumulator width (>= 34)
//
// Ports:
//   system1000       in   1   clock, rising edge
//   system1000_rstn  in   1   asynchronous active-low reset
//   clear            in   1   synchronous flush of history and pipeline state
//   in_valid         in   1   input sample valid
//   in_ready         out  1   block can accept a sample (combinational)
//   in_data          in   16  signed input sample
//   out_valid        out  1   result valid (registered)
//   out_ready        in   1   sink accepts result
//   out_data         out  16  signed saturated result (registered)
//   busy             out  1   high while in MAC or OUT (registered)
//   coef_we          in   1   coefficient write strobe   (FIR_COEF_LOAD_EN)
//   coef_addr        in   2   coefficient index          (FIR_COEF_LOAD_EN)
//   coef_data        in   16  signed coefficient value   (FIR_COEF_LOAD_EN)
//
// Build option:
//   FIR_COEF_LOAD_EN  when defined, the coef_* ports exist and coefficients
//                     can be rewritten while the block is idle; otherwise the
//                     coefficients are the constant COEFS.
// -----------------------------------------------------------------------------

// Invariant checks on the sequencer's control state.
module fir_mac_sequencer_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [1:0] state,
  input logic       out_valid,
  input logic       busy,
  input logic       in_ready
);

  // A result is presented only while the sequencer sits in OUT.
  a_valid_only_in_out: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid == (state == 2'd2));

  // busy mirrors "not idle".
  a_busy_matches_state: assert property (@(posedge clk) disable iff (!rst_n)
    busy == (state != 2'd0));

  // No sample may be taken while the MAC loop owns the delay line.
  a_no_ready_in_mac: assert property (@(posedge clk) disable iff (!rst_n)
    (state == 2'd1) |-> !in_ready);

endmodule

module fir_mac_sequencer #(
  parameter logic [63:0] COEFS     = 64'h2000_2000_2000_2000,
  parameter int          FRAC_BITS = 15,
  parameter int          ACC_W     = 34
) (
  input  logic               system1000,
  input  logic               system1000_rstn,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_data,
  output logic               busy
`ifdef FIR_COEF_LOAD_EN
  ,
  input  logic               coef_we,
  input  logic [1:0]         coef_addr,
  input  logic signed [15:0] coef_data
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Half-LSB rounding constant and the 16-bit clamp limits, all at ACC_W.
  localparam logic signed [ACC_W-1:0] RND    = ACC_W'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32768);

  // Clamp a wide signed value into the signed 16-bit range.
  function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
    logic signed [15:0] r;
    if (v > SAT_HI) begin
      r = 16'sh7FFF;
    end else if (v < SAT_LO) begin
      r = 16'sh8000;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

  state_t                  state_r;
  logic signed [15:0]      x_r [4];
  logic signed [ACC_W-1:0] acc_r;
  logic [1:0]              tap_r;
  logic                    out_valid_r;
  logic signed [15:0]      out_data_r;
  logic                    busy_r;

  logic signed [15:0]      coef_s [4];
  logic signed [15:0]      x_sel_s;
  logic signed [15:0]      c_sel_s;
  logic signed [31:0]      prod_s;
  logic signed [ACC_W-1:0] acc_next_s;
  logic signed [ACC_W-1:0] round_s;
  logic signed [ACC_W-1:0] shift_s;
  logic signed [15:0]      sat_s;
  logic                    in_ready_s;
  logic                    accept_s;

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;
  assign in_ready  = in_ready_s;

  // A handshake on the input side; clear suppresses its effect in the FSM.
  assign accept_s = in_valid & in_ready_s;

`ifdef FIR_COEF_LOAD_EN
  logic signed [15:0] coef_r [4];
  logic               coef_wr_s;

  // Writes land only in IDLE on an edge that does not also take a sample.
  // Under clear no sample is taken, so a coincident write still lands.
  assign coef_wr_s = coef_we && (state_r == ST_IDLE) && !(accept_s && !clear);

  // Coefficient bank: reset to COEFS, rewritable while idle.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int k = 0; k < 4; k++) begin
        coef_r[k] <= COEFS[63-16*k -: 16];
      end
    end else if (coef_wr_s) begin
      coef_r[coef_addr] <= coef_data;
    end
  end

  // Expose the coefficient bank to the datapath.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      coef_s[k] = coef_r[k];
    end
  end
`else
  // Coefficients are fixed at COEFS in this build.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      coef_s[k] = COEFS[63-16*k -: 16];
    end
  end
`endif

  // Select the sample/coefficient pair for the current tap.
  always_comb begin
    x_sel_s = 16'sd0;
    c_sel_s = 16'sd0;
    case (tap_r)
      2'd0: begin x_sel_s = x_r[0]; c_sel_s = coef_s[0]; end
      2'd1: begin x_sel_s = x_r[1]; c_sel_s = coef_s[1]; end
      2'd2: begin x_sel_s = x_r[2]; c_sel_s = coef_s[2]; end
      2'd3: begin x_sel_s = x_r[3]; c_sel_s = coef_s[3]; end
      default: begin x_sel_s = 16'sd0; c_sel_s = 16'sd0; end
    endcase
  end

  // Shared multiplier, accumulate, round-half-up, arithmetic shift, clamp.
  // On the last tap acc_next_s is the final sum, so sat_s is the result.
  assign prod_s     = 32'(x_sel_s) * 32'(c_sel_s);
  assign acc_next_s = acc_r + ACC_W'(prod_s);
  assign round_s    = acc_next_s + RND;
  assign shift_s    = round_s >>> FRAC_BITS;
  assign sat_s      = sat16(shift_s);

  // Input readiness follows the state: free in IDLE, tied to the sink in OUT.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: in_ready_s = 1'b1;
      ST_MAC:  in_ready_s = 1'b0;
      ST_OUT:  in_ready_s = out_ready;
      default: in_ready_s = 1'b0;
    endcase
  end

  // Sequencer FSM with delay line, accumulator and registered outputs.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      out_data_r  <= 16'sd0;
      busy_r      <= 1'b0;
      acc_r       <= {ACC_W{1'b0}};
      tap_r       <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        x_r[k] <= 16'sd0;
      end
    end else if (clear) begin
      // Flush history and any result in flight; coefficients are kept.
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      acc_r       <= {ACC_W{1'b0}};
      tap_r       <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        x_r[k] <= 16'sd0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            x_r[3]  <= x_r[2];
            x_r[2]  <= x_r[1];
            x_r[1]  <= x_r[0];
            x_r[0]  <= in_data;
            acc_r   <= {ACC_W{1'b0}};
            tap_r   <= 2'd0;
            busy_r  <= 1'b1;
            state_r <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc_r <= acc_next_s;
          tap_r <= tap_r + 2'd1;
          if (tap_r == 2'd3) begin
            out_data_r  <= sat_s;
            out_valid_r <= 1'b1;
            state_r     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (accept_s) begin
              // Back-to-back: the next sample enters on the output handshake.
              x_r[3]  <= x_r[2];
              x_r[2]  <= x_r[1];
              x_r[1]  <= x_r[0];
              x_r[0]  <= in_data;
              acc_r   <= {ACC_W{1'b0}};
              tap_r   <= 2'd0;
              state_r <= ST_MAC;
            end else begin
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          tap_r       <= 2'd0;
        end
      endcase
    end
  end

  fir_mac_sequencer_chk u_chk (
    .clk       (system1000),
    .rst_n     (system1000_rstn),
    .state     (state_r),
    .out_valid (out_valid_r),
    .busy      (busy_r),
    .in_ready  (in_ready_s)
  );

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fir_mac_sequencer
//
// Directed bench for fir_mac_sequencer. Two instances share every input: one
// with the default moving-average coefficients and one with all coefficients
// at 0x7FFF, so each vector yields two hand-computed expected outputs.
// -----------------------------------------------------------------------------
module tb_fir_mac_sequencer;

  logic               clk;
  logic               rstn;
  logic               clear;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               out_ready;

  logic               in_ready_a, out_valid_a, busy_a;
  logic signed [15:0] out_data_a;
  logic               in_ready_b, out_valid_b, busy_b;
  logic signed [15:0] out_data_b;

`ifdef FIR_COEF_LOAD_EN
  logic               coef_we;
  logic [1:0]         coef_addr;
  logic signed [15:0] coef_data;
`endif

  int tests_run;
  int tests_failed;

  fir_mac_sequencer dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .clear           (clear),
    .in_valid        (in_valid),
    .in_ready        (in_ready_a),
    .in_data         (in_data),
    .out_valid       (out_valid_a),
    .out_ready       (out_ready),
    .out_data        (out_data_a),
    .busy            (busy_a)
`ifdef FIR_COEF_LOAD_EN
    ,
    .coef_we         (coef_we),
    .coef_addr       (coef_addr),
    .coef_data       (coef_data)
`endif
  );

  fir_mac_sequencer #(.COEFS(64'h7FFF_7FFF_7FFF_7FFF)) dut_sat (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .clear           (clear),
    .in_valid        (in_valid),
    .in_ready        (in_ready_b),
    .in_data         (in_data),
    .out_valid       (out_valid_b),
    .out_ready       (out_ready),
    .out_data        (out_data_b),
    .busy            (busy_b)
`ifdef FIR_COEF_LOAD_EN
    ,
    .coef_we         (coef_we),
    .coef_addr       (coef_addr),
    .coef_data       (coef_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!out_valid_a && n < 20) begin
      tick();
      n++;
    end
    check_val({tag, " lat"}, n, 4);
  endtask

  // Push one sample from IDLE, check the result of both instances, drain it.
  task automatic run_sample(input int d, input int exp_a, input int exp_b, input string tag);
    in_data  = 16'(d);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(tag);
    check_val({tag, " dat"}, int'(out_data_a), exp_a);
    check_val({tag, " sat"}, int'(out_data_b), exp_b);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val({tag, " drop"}, int'(out_valid_a), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int seen;
    tests_run    = 0;
    tests_failed = 0;
    rstn      = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'sd0;
    out_ready = 1'b0;
`ifdef FIR_COEF_LOAD_EN
    coef_we   = 1'b0;
    coef_addr = 2'd0;
    coef_data = 16'sd0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst out_valid", int'(out_valid_a), 0);
    check_val("rst out_data", int'(out_data_a), 0);
    check_val("rst busy", int'(busy_a), 0);
    check_val("rst in_ready", int'(in_ready_a), 1);
    #2 rstn = 1'b1;
    tick();

    // Impulse through the default moving average (and the 0x7FFF bank)
    run_sample(32767, 8192, 32766, "imp0");
    run_sample(0, 8192, 32766, "imp1");
    run_sample(0, 8192, 32766, "imp2");
    run_sample(0, 8192, 32766, "imp3");
    run_sample(0, 0, 0, "imp4");

    // Saturation: ramp full-scale positive, then full-scale negative
    pulse_clear();
    run_sample(32767, 8192, 32766, "satp1");
    run_sample(32767, 16384, 32767, "satp2");
    run_sample(32767, 24575, 32767, "satp3");
    run_sample(32767, 32767, 32767, "satp4");
    run_sample(-32768, 16383, 32767, "satn1");
    run_sample(-32768, 0, -2, "satn2");
    run_sample(-32768, -16384, -32768, "satn3");
    run_sample(-32768, -32768, -32768, "satn4");

    // Latency / throughput with both handshakes held high
    pulse_clear();
    in_data   = 16'sd100;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    for (int k = 1; k <= 15; k++) begin
      tick();
      check_val($sformatf("tp_valid k=%0d", k), int'(out_valid_a), int'(k % 5 == 4));
      check_val($sformatf("tp_ready k=%0d", k), int'(in_ready_a), int'(k % 5 == 4));
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pulse_clear();

    // Backpressure: hold the result, refuse the pending sample
    in_data  = 16'sd32767;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out("bp");
    check_val("bp dat", int'(out_data_a), 8192);
    in_data  = 16'sd1234;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_val($sformatf("bp hold_valid %0d", k), int'(out_valid_a), 1);
      check_val($sformatf("bp hold_data %0d", k), int'(out_data_a), 8192);
      check_val($sformatf("bp hold_ready %0d", k), int'(in_ready_a), 0);
    end
    out_ready = 1'b1;
    #1;
    check_val("bp ready_follow", int'(in_ready_a), 1);
    tick();
    check_val("bp hs_valid", int'(out_valid_a), 0);
    check_val("bp hs_busy", int'(busy_a), 1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    wait_out("bp2");
    check_val("bp2 dat", int'(out_data_a), 8500);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Clear on the second MAC cycle wipes the result and the history
    in_data  = 16'sd5000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    seen = 0;
    repeat (8) begin
      tick();
      if (out_valid_a) seen = 1;
    end
    check_val("clr no_valid", seen, 0);
    check_val("clr busy", int'(busy_a), 0);
    run_sample(32767, 8192, 32766, "clr_imp");

    // Asynchronous reset while a result is held in OUT
    in_data  = 16'sd32767;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out("ro");
    check_val("ro dat", int'(out_data_a), 16384);
    check_val("ro sat", int'(out_data_b), 32767);
    #2 rstn = 1'b0;
    #1;
    check_val("ro async_valid", int'(out_valid_a), 0);
    check_val("ro async_data", int'(out_data_a), 0);
    check_val("ro async_busy", int'(busy_a), 0);
    #2 rstn = 1'b1;
    tick();
    run_sample(32767, 8192, 32766, "rst_imp");

`ifdef FIR_COEF_LOAD_EN
    // A coefficient write issued during MAC is dropped
    pulse_clear();
    in_data  = 16'sd32767;
    in_valid = 1'b1;
    tick();
    in_valid  = 1'b0;
    coef_we   = 1'b1;
    coef_addr = 2'd0;
    coef_data = 16'sh4000;
    tick();
    coef_we = 1'b0;
    wait_out("cw_mac");
    check_val("cw_mac dat", int'(out_data_a), 8192);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    pulse_clear();
    run_sample(32767, 8192, 32766, "cw_mac_after");

    // The same write in IDLE takes effect
    pulse_clear();
    coef_we   = 1'b1;
    coef_addr = 2'd0;
    coef_data = 16'sh4000;
    tick();
    coef_we = 1'b0;
    run_sample(32767, 16384, 16384, "cw_idle");

    // A write coincident with clear still lands (c[1] <= 0)
    coef_we   = 1'b1;
    coef_addr = 2'd1;
    coef_data = 16'sd0;
    clear     = 1'b1;
    tick();
    coef_we = 1'b0;
    clear   = 1'b0;
    run_sample(32767, 16384, 16384, "cw_clr0");
    run_sample(0, 0, 0, "cw_clr1");
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Time-multiplexed 4-tap FIR controller: one signed 16x16 multiplier and one accumulator shared across all taps, sequenced over 4 cycles per output sample.
- Owns the 4-entry signed-16 sample delay line and the 4 coefficient registers.
- Sits between the sample source and sink on valid/ready handshakes; the area-saving alternative to the fully parallel FIR.

Parameters:
- COEFS, 64'h2000_2000_2000_2000: reset coefficients; c[k] = COEFS[63-16k -: 16], signed Q1.15. Default is a 4-tap moving average (0.25 each).
- FRAC_BITS, 15: right shift applied to the accumulator before saturation; legal range 1..30.
- ACC_W, 34: accumulator width; must be >= 34.

Ports:
- system1000  in  1  clock, rising edge.
- system1000_rstn  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous flush.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  16  signed input sample.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- out_data  out  16  signed saturated result, registered.
- busy  out  1  high while the state is MAC or OUT.
- coef_we  in  1  coefficient write strobe (FIR_COEF_LOAD_EN only).
- coef_addr  in  2  coefficient index (FIR_COEF_LOAD_EN only).
- coef_data  in  16  signed coefficient (FIR_COEF_LOAD_EN only).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. Clock port is system1000, reset port is system1000_rstn.
- Reset values: state=IDLE, out_valid=0, out_data=0, busy=0, acc=0, tap=0, delay line x[0..3]=0, c[k]=COEFS.
- in_ready is combinational: 1 in IDLE, out_ready in OUT, 0 in MAC.
- IDLE: an accept (in_valid & in_ready) shifts the delay line, x[3]<=x[2], x[2]<=x[1], x[1]<=x[0], x[0]<=in_data. It also clears acc and tap, then goes to MAC.
- MAC: each edge does acc <= acc + x[tap]*c[tap] (full 32-bit signed product, sign-extended to ACC_W), then tap++.
- On the tap==3 edge: register out_data <= sat16((acc_final + 2^(FRAC_BITS-1)) >>> FRAC_BITS), set out_valid=1, go to OUT.
- sat16 clamps to [-32768, 32767].
- OUT: out_valid and out_data are held stable until out_ready.
  - On out_ready: out_valid drops.
  - If in_valid is also high, the new sample is accepted on the same edge and the state goes to MAC; otherwise the state goes to IDLE.
- Latency: out_valid is visible 4 cycles after the accepting edge. Sustained throughput: 1 result per 5 cycles.
- clear: in any state it zeroes x[], acc, tap and out_valid, and forces IDLE. It overrides any simultaneous handshake and does not touch the coefficients.
- Async reset asserted mid-operation: all state returns to reset values immediately; no partial result is emitted.

Optional Feature:
- Macro FIR_COEF_LOAD_EN.
- Defined:
  - The coef_we/coef_addr/coef_data ports exist.
  - A write updates c[coef_addr] at the edge, only when state==IDLE and no accept occurs that edge. Writes arriving otherwise are dropped silently; software polls busy.
  - A write coincident with clear still takes effect.
- Undefined: the ports are absent; coefficients are constant at COEFS.

Test Plan:
- Impulse, default COEFS: accept 32767 then three 0s -> out_data 8192, 8192, 8192, 8192; a fifth 0 -> 0.
- Latency/throughput: in_valid=1 and out_ready=1 held -> first out_valid 4 cycles after first accept; out_valid pulses every 5 cycles; in_ready high exactly on output-handshake edges.
- Saturation: COEFS=64'h7FFF_7FFF_7FFF_7FFF (or written via the macro), four samples of 32767 -> 4th out_data 32767; four samples of -32768 -> 4th out_data -32768.
- Backpressure: out_ready=0 for 10 cycles in OUT -> out_valid=1 and out_data constant; in_ready=0; a pending in_valid is not accepted. Raising out_ready -> output and input handshakes occur on the same edge.
- Clear and reset: clear pulsed on the 2nd MAC cycle -> no out_valid, and a following impulse of 32767 yields 8192 with no old history. system1000_rstn low during OUT -> out_valid and out_data go to 0 without waiting for a clock edge.
- FIR_COEF_LOAD_EN: write c[0]=16'h4000 in IDLE -> impulse 32767 gives first output 16384. The same write issued during MAC is dropped -> output 8192.
